// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: the requester and data_memory signals of dmem_arbiter.
// Port 0 carries CPU MEM-stage requests and port 1 carries loader/debug requests.
// Each port has req, we, byte, addr and wdata going in, and done, err and rdata
// coming out. The memory side carries the mem_* strobes and mem_read_data.
// The slave modport is the arbiter's view and the master modport is the other side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic              byte0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;
    logic              err0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic              byte1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;
    logic              err1;
    logic [DATA_W-1:0] rdata1;

    logic              busy;
    logic              mem_write;
    logic              mem_byte_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, we0, byte0, addr0, wdata0,
        input  req1, we1, byte1, addr1, wdata1,
        input  mem_read_data,
        output done0, err0, rdata0,
        output done1, err1, rdata1,
        output busy,
        output mem_write, mem_byte_en, mem_address, mem_write_data
    );

    modport master (
        output req0, we0, byte0, addr0, wdata0,
        output req1, we1, byte1, addr1, wdata1,
        output mem_read_data,
        input  done0, err0, rdata0,
        input  done1, err1, rdata1,
        input  busy,
        input  mem_write, mem_byte_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory between two requesters. Port 0 is the
// CPU and port 1 is the loader. Each access runs IDLE, SETUP, ACCESS and RELEASE.
// Ports are clk, reset (asynchronous, active-high) and bus (dmem_arbiter_if.slave).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration. Without it, port 0
// has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RELEASE
    } state_t;

    state_t state;

    logic owner;
    logic latWe;
    logic misAl;

    logic              grantPort;
    logic              winWe;
    logic              winByte;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;
    logic [DATA_W-1:0] readVal;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Holds the port granted last. Its reset value of 1 makes port 0 win first.
    logic lastGrant;

    always_comb begin
        if (bus.req0 && bus.req1) begin
            grantPort = ~lastGrant;
        end else begin
            grantPort = ~bus.req0;
        end
    end
`else
    always_comb begin
        grantPort = ~bus.req0;
    end
`endif

    always_comb begin
        winWe    = grantPort ? bus.we1    : bus.we0;
        winByte  = grantPort ? bus.byte1  : bus.byte0;
        winAddr  = grantPort ? bus.addr1  : bus.addr0;
        winWdata = grantPort ? bus.wdata1 : bus.wdata0;
    end

    // Byte reads zero-extend. The CPU handles sign extension.
    always_comb begin
        if (bus.mem_byte_en) begin
            readVal = {{(DATA_W-8){1'b0}}, bus.mem_read_data[7:0]};
        end else begin
            readVal = bus.mem_read_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            owner              <= 1'b0;
            latWe              <= 1'b0;
            misAl              <= 1'b0;
            bus.busy           <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_byte_en    <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.done0          <= 1'b0;
            bus.done1          <= 1'b0;
            bus.err0           <= 1'b0;
            bus.err1           <= 1'b0;
            bus.rdata0         <= '0;
            bus.rdata1         <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            lastGrant          <= 1'b1;
`endif
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner              <= grantPort;
                        latWe              <= winWe;
                        misAl              <= ~winByte & winAddr[0];
                        // The bus registers double as the latched command.
                        bus.mem_address    <= winAddr;
                        bus.mem_write_data <= winWdata;
                        bus.mem_byte_en    <= winByte;
                        bus.busy           <= 1'b1;
                        state              <= SETUP;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        lastGrant          <= grantPort;
`endif
                    end
                end
                SETUP: begin
                    bus.mem_write <= latWe & ~misAl;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    bus.mem_write <= 1'b0;
                    if (!latWe && !misAl) begin
                        if (owner) begin
                            bus.rdata1 <= readVal;
                        end else begin
                            bus.rdata0 <= readVal;
                        end
                    end
                    if (owner) begin
                        bus.done1 <= 1'b1;
                        bus.err1  <= misAl;
                    end else begin
                        bus.done0 <= 1'b1;
                        bus.err0  <= misAl;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and corner-case sequences for dmem_arbiter.
// A byte-array model stands in for data_memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic memInit = 1'b1;
    int   nCmp = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Little-endian byte memory. A byte read returns the addressed byte in [7:0].
    logic [7:0] mem [0:255];
    logic [7:0] aLo;
    logic [7:0] aHi;
    assign aLo = bus.mem_address[7:0];
    assign aHi = aLo + 8'd1;
    assign bus.mem_read_data = bus.mem_byte_en ? {8'h00, mem[aLo]}
                                               : {mem[aHi], mem[aLo]};

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        end else if (bus.mem_write) begin
            if (bus.mem_byte_en) begin
                mem[aLo] = bus.mem_write_data[7:0];
            end else begin
                mem[aLo] = bus.mem_write_data[7:0];
                mem[aHi] = bus.mem_write_data[15:8];
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic        isByte;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        expErr;
        int          expWr;
        logic [15:0] expRd0;
        logic [15:0] expRd1;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic runTxn(input int idx, input vec_t v);
        int lat;
        int wr;
        bit hold;
        bit other;
        bit got;
        logic errSeen;
        lat = 0; wr = 0; hold = 1; other = 0; got = 0; errSeen = 0;
        bus.req0 = ~v.port; bus.req1 = v.port;
        bus.we0 = v.we; bus.we1 = v.we;
        bus.byte0 = v.isByte; bus.byte1 = v.isByte;
        bus.addr0 = v.addr; bus.addr1 = v.addr;
        bus.wdata0 = v.wdata; bus.wdata1 = v.wdata;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (bus.mem_write) wr++;
            if (bus.mem_address !== v.addr || bus.mem_byte_en !== v.isByte ||
                bus.mem_write_data !== v.wdata) hold = 0;
            if (v.port ? bus.done0 : bus.done1) other = 1;
            if (v.port ? bus.done1 : bus.done0) begin
                got = 1;
                lat = n;
                errSeen = v.port ? bus.err1 : bus.err0;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, 3);
        chk($sformatf("v%0d writes", idx), wr, v.expWr);
        chk($sformatf("v%0d err", idx), {31'b0, errSeen}, {31'b0, v.expErr});
        chk($sformatf("v%0d bushold", idx), {31'b0, hold}, 1);
        chk($sformatf("v%0d otherdone", idx), {31'b0, other}, 0);
        chk($sformatf("v%0d rdata0", idx), {16'b0, bus.rdata0}, {16'b0, v.expRd0});
        chk($sformatf("v%0d rdata1", idx), {16'b0, bus.rdata1}, {16'b0, v.expRd1});
        @(negedge clk);
        chk($sformatf("v%0d donepulse", idx),
            {30'b0, bus.done0, bus.done1}, 0);
        chk($sformatf("v%0d busyidle", idx), {31'b0, bus.busy}, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        int both;
        int seq [4];
        int expSeq [4];
        vec_t v;

        //        port we  byte addr      wdata     err wr rd0       rd1
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 16'hABCD, 1'b0, 1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h5A5A, 1'b0, 1, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 0, 16'h0000, 16'hABCD};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b0, 0, 16'h0000, 16'h00CD};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h1234, 1'b1, 0, 16'h0000, 16'h00CD};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 0, 16'h5A5A, 16'h00CD};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0077, 1'b0, 1, 16'h5A5A, 16'h00CD};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 0, 16'h5A5A, 16'h77CD};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 0, 16'h5A5A, 16'h77CD};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 0, 16'h5A5A, 16'h0077};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 0, 16'h5A5A, 16'h0077};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0003, 16'h0011, 1'b0, 1, 16'h5A5A, 16'h0077};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 0, 16'h115A, 16'h0077};

        bus.req0 = 0; bus.we0 = 0; bus.byte0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.byte1 = 0; bus.addr1 = 0; bus.wdata1 = 0;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        memInit = 1'b0;
        chk("rst busy", {31'b0, bus.busy}, 0);
        chk("rst memctl", {30'b0, bus.mem_write, bus.mem_byte_en}, 0);
        chk("rst membus", {bus.mem_address, bus.mem_write_data}, 0);
        chk("rst done/err", {28'b0, bus.done0, bus.done1, bus.err0, bus.err1}, 0);
        chk("rst rdata", {bus.rdata0, bus.rdata1}, 0);

        for (int i = 0; i < 13; i++) runTxn(i, vecs[i]);

        // Assert reset in the ACCESS cycle of a write, then complete it.
        bus.we0 = 1; bus.byte0 = 0; bus.addr0 = 16'h0008; bus.wdata0 = 16'hBEEF;
        bus.req0 = 1;
        @(negedge clk);
        @(negedge clk);
        chk("mid access mw", {31'b0, bus.mem_write}, 1);
        chk("mid access busy", {31'b0, bus.busy}, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid rst mw", {31'b0, bus.mem_write}, 0);
        chk("mid rst busy", {31'b0, bus.busy}, 0);
        @(negedge clk);
        chk("mid rst done", {30'b0, bus.done0, bus.done1}, 0);
        reset = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (bus.done0) lat = n;
        end
        bus.req0 = 0;
        chk("mid rerun latency", lat, 3);
        @(negedge clk);
        v = '{1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000, 1'b0, 0, 16'hBEEF, 16'h0000};
        runTxn(13, v);

        // Both ports hold req high for 16 cycles.
        doReset();
        bus.we0 = 0; bus.byte0 = 0; bus.addr0 = 16'h0004;
        bus.we1 = 0; bus.byte1 = 0; bus.addr1 = 16'h0004;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        expSeq = '{0, 1, 0, 1};
`else
        expSeq = '{0, 0, 0, 0};
`endif
        seq = '{9, 9, 9, 9};
        k = 0;
        both = 0;
        bus.req0 = 1;
        bus.req1 = 1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (bus.done0 && bus.done1) both++;
            if (bus.done0 && k < 4) begin seq[k] = 0; k++; end
            if (bus.done1 && k < 4) begin seq[k] = 1; k++; end
        end
        bus.req0 = 0;
        bus.req1 = 0;
        chk("cont count", k, 4);
        chk("cont both", both, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("cont seq%0d", i), seq[i], expSeq[i]);
        chk("cont rdata0", {16'b0, bus.rdata0}, 32'h77CD);
        repeat (4) @(negedge clk);
        chk("cont idle", {31'b0, bus.busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
